// File: rtl/if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_ctrl
// Description : Instruction-fetch controller. Walks a 32-bit pc through
//               instruction memory with a combinational request / ack
//               handshake. It holds one fetched word for the IF/ID stage,
//               honours downstream stall, and redirects on branch.
//
//               Optional feature: when the macro FETCH_TIMEOUT_EN is defined,
//               a watchdog counts request cycles that receive no ack. After
//               TIMEOUT_CYCLES such cycles in a row, the block parks in ERR
//               and raises the sticky fetch_err_o flag. Only a branch or a
//               reset leaves ERR. When the macro is undefined there is no
//               watchdog, fetch_err_o is tied low, and the block waits for
//               an ack indefinitely.
//
// Parameters  : RESET_PC        first fetch address after reset
//               TIMEOUT_CYCLES  watchdog limit (FETCH_TIMEOUT_EN only)
// Ports       : clk              clock, rising edge
//               rst              synchronous reset, active low
//               stall_i          IF/ID cannot accept a word this cycle
//               branch_flag_i    redirect request
//               branch_target_i  redirect address (low two bits ignored)
//               mem_ack_i        mem_rdata_i valid for mem_addr_o
//               mem_rdata_i      instruction word from memory
//               ce_o             instruction-memory chip enable
//               mem_req_o        fetch request (combinational)
//               mem_addr_o       fetch address (= pc)
//               inst_valid_o     inst_o / inst_pc_o hold an unconsumed word
//               inst_o           fetched word
//               inst_pc_o        address of fetched word
//               fetch_err_o      sticky fetch-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module if_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        ce_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        fetch_err_o
);

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        w_mem_req;
    logic        w_accept;
    logic        w_consume;
    logic        w_redirect;
    logic        w_timeout;

    // A zero limit would make the watchdog compare against an underflowed value.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("if_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // Request is suppressed while a held word is blocked and on a redirect
    // cycle, so any ack arriving then is ignored by construction.
    assign w_mem_req  = (r_state == RUN) && !(inst_valid_o && stall_i) && !branch_flag_i;
    assign w_accept   = w_mem_req && mem_ack_i;
    assign w_consume  = inst_valid_o && !stall_i;
    assign w_redirect = branch_flag_i && (r_state != IDLE);

    assign mem_req_o  = w_mem_req;
    assign mem_addr_o = r_pc;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = RUN;
            RUN: begin
                // w_timeout is already low on a branch cycle (request dropped).
                if (w_timeout) begin
                    w_state_nxt = ERR;
                end
            end
            ERR: begin
                if (branch_flag_i) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // pc and fetched-word holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ce_o         <= 1'b0;
            r_pc         <= RESET_PC;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'h0;
            inst_pc_o    <= 32'h0;
        end else begin
            ce_o <= 1'b1;
            if (w_redirect) begin
                r_pc         <= branch_target_i & c_ALIGN_MASK;
                inst_valid_o <= 1'b0;
            end else if (w_accept) begin
                inst_o       <= mem_rdata_i;
                inst_pc_o    <= r_pc;
                inst_valid_o <= 1'b1;
                r_pc         <= r_pc + 32'd4;
            end else if (w_consume) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fetch watchdog
    // ------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              r_fetch_err;

    // Fires on the TIMEOUT_CYCLES-th consecutive unanswered request cycle.
    assign w_timeout = w_mem_req && !mem_ack_i &&
                       (r_wdog == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (!w_mem_req || mem_ack_i || w_timeout) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + c_WD_W'(1);
            end

            if ((r_state == ERR) && branch_flag_i) begin
                r_fetch_err <= 1'b0;
            end else if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign fetch_err_o = r_fetch_err;
`else
    assign w_timeout   = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_ctrl
// Description : Directed self-checking bench for if_ctrl. A memory model
//               answers every address with a fixed function of it. The
//               expected fetch addresses go into a queue as requests are
//               acked, and they come out and are compared when the DUT hands
//               a word downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        ce_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fetch_err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
    endfunction

    assign mem_rdata_i = memf(mem_addr_o);

    if_ctrl #(
        .RESET_PC       (c_RESET_PC),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .ce_o            (ce_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .fetch_err_o     (fetch_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ce"},        32'(ce_o),         32'd0);
        chk({tag, "_req"},       32'(mem_req_o),    32'd0);
        chk({tag, "_addr"},      mem_addr_o,        c_RESET_PC);
        chk({tag, "_valid"},     32'(inst_valid_o), 32'd0);
        chk({tag, "_inst"},      inst_o,            32'd0);
        chk({tag, "_inst_pc"},   inst_pc_o,         32'd0);
        chk({tag, "_fetch_err"}, 32'(fetch_err_o),  32'd0);
    endtask

    // One clock cycle with the inputs the caller has already set. Checks the
    // combinational request, retires a consumed word against the scoreboard,
    // records an expected acked fetch, then advances past the rising edge.
    task automatic tick(input logic exp_req);
        logic [31:0] pc_w;
        #1;
        chk("mem_req", 32'(mem_req_o), 32'(exp_req));
        if (exp_req) chk("mem_addr", mem_addr_o, exp_pc);
        if (inst_valid_o === 1'b1 && stall_i == 1'b0) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL word_unexpected: observed pc %h expected none", inst_pc_o);
            end
            if (sb.size() != 0) begin
                pc_w = sb.pop_front();
                chk("inst_pc", inst_pc_o, pc_w);
                chk("inst",    inst_o,    memf(pc_w));
            end
        end
        if (exp_req && mem_ack_i) begin
            sb.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        mem_ack_i       = 1'b1;
        exp_pc          = c_RESET_PC;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");

        // Release; a branch while still in IDLE must be ignored
        rst             = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0500;
        tick(1'b0);
        branch_flag_i   = 1'b0;
        chk("ce_after_release", 32'(ce_o), 32'd1);
        chk("idle_branch_ignored", mem_addr_o, c_RESET_PC);

        // Streaming at one word per cycle; inst_pc trails mem_addr by one
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            chk("pc_trail", inst_pc_o, exp_pc - 32'd4);
            chk("valid_stream", 32'(inst_valid_o), 32'd1);
        end

        // Stall three cycles holding the 0x8 word; ack is ignored meanwhile
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("stall_valid",   32'(inst_valid_o), 32'd1);
            chk("stall_inst_pc", inst_pc_o,         32'h8);
            chk("stall_inst",    inst_o,            memf(32'h8));
            chk("stall_pc_hold", mem_addr_o,        32'hC);
        end
        stall_i = 1'b0;
        tick(1'b1);
        chk("fetch_c_after_stall", inst_pc_o, 32'hC);
        tick(1'b1);

        // Branch while stalled with a valid word; the ack that cycle is dropped
        stall_i = 1'b1;
        tick(1'b0);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_1003;
        tick(1'b0);
        branch_flag_i = 1'b0;
        sb.delete();
        exp_pc = 32'h0000_1000;
        chk("branch_kill_valid", 32'(inst_valid_o), 32'd0);
        chk("branch_addr",       mem_addr_o,        32'h0000_1000);
        stall_i = 1'b0;
        tick(1'b1);
        tick(1'b1);

        // pc wrap at the top of the address space
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        tick(1'b0);
        branch_flag_i = 1'b0;
        sb.delete();
        exp_pc = 32'hFFFF_FFFC;
        chk("wrap_branch_addr", mem_addr_o, 32'hFFFF_FFFC);
        tick(1'b1);
        chk("wrap_inst_pc", inst_pc_o,  32'hFFFF_FFFC);
        chk("wrap_addr",    mem_addr_o, 32'h0000_0000);
        tick(1'b1);

        // No ack for a long stretch
        mem_ack_i = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (16) tick(1'b1);
        chk("timeout_err", 32'(fetch_err_o), 32'd1);
        tick(1'b0);
        chk("err_sticky",  32'(fetch_err_o), 32'd1);
        chk("err_pc_hold", mem_addr_o,       32'h4);
`else
        repeat (20) tick(1'b1);
        chk("no_wdog_err",  32'(fetch_err_o), 32'd0);
        chk("wait_pc_hold", mem_addr_o,       32'h4);
`endif
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0040;
        tick(1'b0);
        branch_flag_i = 1'b0;
        sb.delete();
        exp_pc = 32'h0000_0040;
        chk("err_cleared", 32'(fetch_err_o), 32'd0);
        mem_ack_i = 1'b1;
        tick(1'b1);
        chk("resume_0x40", inst_pc_o, 32'h40);

        // Reset mid-stream with pc at 0x20 and a request pending
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0018;
        tick(1'b0);
        branch_flag_i = 1'b0;
        sb.delete();
        exp_pc = 32'h0000_0018;
        tick(1'b1);
        tick(1'b1);
        chk("pre_reset_pc", mem_addr_o, 32'h20);
        rst = 1'b0;
        tick(1'b1);
        sb.delete();
        exp_pc = c_RESET_PC;
        chk_reset("mid");

        // Restart from RESET_PC
        rst = 1'b1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        mem_ack_i = 1'b0;
        tick(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the fetch watchdog limit; it is used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset: rst==0 at a rising clk edge resets the block.
REQ-005 stall_i  input  1  SHALL indicate that the downstream IF/ID stage cannot accept a word this cycle.
REQ-006 branch_flag_i  input  1  SHALL request a fetch redirect this cycle.
REQ-007 branch_target_i  input  32  SHALL be the redirect address.
REQ-008 mem_ack_i  input  1  SHALL indicate that mem_rdata_i is valid for mem_addr_o this cycle.
REQ-009 mem_rdata_i  input  32  SHALL be the instruction word from memory.
REQ-010 ce_o  output  1  SHALL be the instruction-memory chip enable.
REQ-011 mem_req_o  output  1  SHALL be the fetch request.
REQ-012 mem_addr_o  output  32  SHALL be the fetch address; it is always equal to the internal pc.
REQ-013 inst_valid_o  output  1  SHALL indicate that inst_o and inst_pc_o hold an unconsumed word.
REQ-014 inst_o / inst_pc_o  output  32 each  SHALL be the fetched word and its address.
REQ-015 fetch_err_o  output  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and ERR.
- IDLE->RUN on the first edge with rst==1; ce_o<=1 on that edge.
- ERR is reachable only with the macro defined.
REQ-017 mem_req_o SHALL equal (state==RUN) && !(inst_valid_o && stall_i) && !branch_flag_i.
- This term is combinational.
- mem_ack_i SHALL be ignored whenever mem_req_o==0.
REQ-018 A word SHALL be consumed in any cycle where inst_valid_o==1 && stall_i==0.
REQ-019 On an accepted fetch (mem_req_o && mem_ack_i):
- inst_o<=mem_rdata_i, inst_pc_o<=pc, inst_valid_o<=1.
- pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 If a word is consumed with no accepted fetch in the same cycle, inst_valid_o<=0.
REQ-021 Throughput SHALL be one word per cycle while mem_ack_i==1 and stall_i==0; accept-to-valid latency is 1 cycle.
REQ-022 While inst_valid_o==1 and stall_i==1, inst_o, inst_pc_o and pc SHALL hold.
REQ-023 branch_flag_i==1 SHALL take priority over ack, stall and timeout.
- pc<={branch_target_i[31:2],2'b00}.
- inst_valid_o<=0; any held word is killed.
- Any ack in the same cycle is discarded.
- State<=RUN (from RUN or ERR).
REQ-024 branch_flag_i SHALL be ignored in IDLE.

Reset
REQ-025 Reset SHALL set: state=IDLE, pc=RESET_PC, ce_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_err_o=0, watchdog=0.
REQ-026 Reset SHALL override every other input, including mid-fetch and mid-stall.
- A pending request SHALL drop in the same cycle as the reset edge.
- No pc increment SHALL occur.

Configuration
REQ-027 With FETCH_TIMEOUT_EN defined, a watchdog SHALL behave as follows:
- It counts consecutive cycles with mem_req_o==1 && mem_ack_i==0.
- It clears on any ack, on a branch, or when mem_req_o==0.
- When the count reaches TIMEOUT_CYCLES: state<=ERR, fetch_err_o<=1, mem_req_o==0, pc holds.
- ERR exits only via branch (fetch_err_o<=0) or reset.
REQ-028 With FETCH_TIMEOUT_EN undefined:
- No watchdog logic exists.
- fetch_err_o SHALL be constant 0.
- The block waits indefinitely for ack.

Verification
REQ-029 Reset release, mem_ack_i=1, stall_i=0 -> ce_o=1 after 1 edge; mem_addr_o=0,4,8,... one per cycle; inst_pc_o trails mem_addr_o by one cycle.
REQ-030 stall_i=1 for 3 cycles while inst_valid_o=1 with inst_pc_o=0x8 -> mem_req_o=0; inst_o/inst_pc_o hold 0x8 word; the 0xC fetch occurs in the cycle stall_i falls.
REQ-031 branch_flag_i=1 with target 0x0000_1003 while stalled with a valid word -> next cycle inst_valid_o=0, mem_addr_o=0x0000_1000; the ack in the branch cycle is discarded.
REQ-032 pc=0xFFFF_FFFC, ack -> inst_pc_o=0xFFFF_FFFC and mem_addr_o=0x0000_0000.
REQ-033 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ack_i=0 for 16 cycles -> fetch_err_o=1 and mem_req_o=0; a later branch to 0x40 clears fetch_err_o and fetching resumes at 0x40.
REQ-034 rst=0 for one edge mid-stream at pc=0x20 -> all outputs at their reset values next cycle; fetch restarts at RESET_PC.
